// File: rtl/fir_n.sv
// fir_n: decimating FIR filter between two first-word-fall-through FIFOs.
// Samples are shifted into a tap line, then a single multiply-accumulate
// walks the taps one per cycle before the result is pushed downstream.
module fir_n #(
  parameter int DATA_WIDTH  = 32,
  parameter int COEFF_WIDTH = 32,
  parameter int TAPS        = 32,
  parameter int DECIM       = 1,
  parameter int FRAC_BITS   = 10
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic                     in_empty,
  output logic                     in_rd_en,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic                     out_wr_en,
  input  logic                     out_full,
  input  logic                     coeff_wr_en,
  input  logic [$clog2(TAPS)-1:0]  coeff_addr,
  input  logic [COEFF_WIDTH-1:0]   coeff_din,
  output logic                     busy
);

  localparam int IDX_W  = $clog2(TAPS);
  localparam int CNT_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int PROD_W = DATA_WIDTH + COEFF_WIDTH;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    MAC   = 2'd1,
    WRITE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   tap_q   [TAPS];
  logic [COEFF_WIDTH-1:0]  coeff_q [TAPS];
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]        popCnt_q, popCnt_d;
  logic [IDX_W-1:0]        macIdx_q, macIdx_d;

  logic                    lastPop;
  logic                    lastMac;
  logic                    coeffWe;
  logic signed [PROD_W-1:0] product;
  logic signed [PROD_W-1:0] productShifted;

  assign lastPop = (popCnt_q == CNT_W'(DECIM - 1));
  assign lastMac = (macIdx_q == IDX_W'(TAPS - 1));

  // Coefficients are frozen while a result is being computed or held, and
  // indices past the last tap (non-power-of-two TAPS) are dropped.
  assign coeffWe = coeff_wr_en && !busy && (int'(coeff_addr) < TAPS);

  // Full-width signed product of the current tap, dequantised by an
  // arithmetic shift; only the low DATA_WIDTH bits reach the accumulator.
  always_comb begin
    product        = PROD_W'($signed(tap_q[macIdx_q])) * PROD_W'($signed(coeff_q[macIdx_q]));
    productShifted = product >>> FRAC_BITS;
  end

  assign dout = acc_q;
  assign busy = (state_q != LOAD);

  // Next-state, handshake strobes and datapath updates for LOAD/MAC/WRITE.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    popCnt_d  = popCnt_q;
    macIdx_d  = macIdx_q;
    in_rd_en  = 1'b0;
    out_wr_en = 1'b0;
    case (state_q)
      LOAD: begin
        in_rd_en = reset && !in_empty;
        if (in_rd_en) begin
          if (lastPop) begin
            popCnt_d = '0;
            acc_d    = '0;
            macIdx_d = '0;
            state_d  = MAC;
          end else begin
            popCnt_d = popCnt_q + 1'b1;
          end
        end
      end
      MAC: begin
        acc_d = acc_q + DATA_WIDTH'(productShifted);
        if (lastMac) begin
          state_d = WRITE;
        end else begin
          macIdx_d = macIdx_q + 1'b1;
        end
      end
      WRITE: begin
        out_wr_en = reset && !out_full;
        if (out_wr_en) begin
          state_d = LOAD;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // Control and accumulator registers; reset abandons any pending result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= LOAD;
      acc_q    <= '0;
      popCnt_q <= '0;
      macIdx_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      popCnt_q <= popCnt_d;
      macIdx_q <= macIdx_d;
    end
  end

  // Tap delay line: every pop shifts the newest sample into tap 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < TAPS; k++) begin
        tap_q[k] <= '0;
      end
    end else if (in_rd_en) begin
      tap_q[0] <= din;
      for (int k = 1; k < TAPS; k++) begin
        tap_q[k] <= tap_q[k-1];
      end
    end
  end

  // Coefficient bank, writable only while the filter is idle in LOAD.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < TAPS; k++) begin
        coeff_q[k] <= '0;
      end
    end else if (coeffWe) begin
      coeff_q[coeff_addr] <= coeff_din;
    end
  end

endmodule

// File: doc/fir_n.md
FIR_N -- requirements
Module: fir_n

Interface
REQ-001 SHALL expose parameter DATA_WIDTH, default 32, the sample and output width in two's complement.
REQ-002 SHALL expose parameter COEFF_WIDTH, default 32, the coefficient width in two's complement.
REQ-003 SHALL expose parameter TAPS, default 32, the filter length; legal range 2..256.
REQ-004 SHALL expose parameter DECIM, default 1, the decimation factor (input samples consumed per output); legal range 1..16.
REQ-005 SHALL expose parameter FRAC_BITS, default 10, the fixed-point dequantisation shift.
REQ-006 SHALL have port clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port din, input, DATA_WIDTH bits: the head word of the upstream FIFO, valid whenever in_empty=0 (first-word-fall-through).
REQ-009 SHALL have port in_empty, input, 1 bit: the upstream FIFO is empty.
REQ-010 SHALL have port in_rd_en, output, 1 bit: pops the upstream FIFO.
REQ-011 SHALL have port dout, output, DATA_WIDTH bits: the filtered sample.
REQ-012 SHALL have port out_wr_en, output, 1 bit: pushes dout into the downstream FIFO.
REQ-013 SHALL have port out_full, input, 1 bit: the downstream FIFO is full.
REQ-014 SHALL have port coeff_wr_en, input, 1 bit: coefficient write strobe.
REQ-015 SHALL have port coeff_addr, input, $clog2(TAPS) bits: the coefficient index.
REQ-016 SHALL have port coeff_din, input, COEFF_WIDTH bits: the coefficient value.
REQ-017 SHALL have port busy, output, 1 bit: high in states MAC and WRITE.

Function
REQ-018 SHALL hold TAPS sample registers tap[0..TAPS-1] (tap[0] newest) and TAPS coefficient registers coeff[0..TAPS-1].
REQ-019 SHALL implement FSM states LOAD, MAC and WRITE.
REQ-020 In LOAD, SHALL set in_rd_en = !in_empty combinationally; each cycle with in_rd_en=1 shifts din into tap[0] and tap[k] into tap[k+1].
REQ-021 SHALL leave LOAD for MAC on the cycle the DECIM-th pop since the last output occurs; the pop counter resets to 0 on entry to MAC.
REQ-022 MAC SHALL take exactly TAPS cycles, one product per cycle, index k=0..TAPS-1: acc += (tap[k]*coeff[k]) >>> FRAC_BITS.
REQ-023 Each product SHALL be a full DATA_WIDTH+COEFF_WIDTH signed product, arithmetically shifted, then truncated to DATA_WIDTH; acc SHALL be DATA_WIDTH bits and wrap modulo 2^DATA_WIDTH with no saturation.
REQ-024 acc SHALL be cleared on entry to MAC.
REQ-025 In WRITE, SHALL set out_wr_en = !out_full and dout = acc; on the out_wr_en cycle the FSM returns to LOAD.
REQ-026 While out_full=1 in WRITE, SHALL hold dout and the state; no sample is dropped.
REQ-027 in_rd_en SHALL be 0 outside LOAD; out_wr_en SHALL be 0 outside WRITE.
REQ-028 Latency from the DECIM-th pop to out_wr_en SHALL be TAPS+1 cycles with out_full=0; steady-state throughput SHALL be one output per max(DECIM, 1)+TAPS+1 cycles.
REQ-029 A coefficient write SHALL update coeff[coeff_addr] at the clock edge only while busy=0; while busy=1, coeff_wr_en SHALL be ignored.
REQ-030 A write and a pop in the same LOAD cycle SHALL both take effect.
REQ-031 If coeff_addr >= TAPS (non-power-of-two TAPS), the write SHALL be ignored.

Reset
REQ-032 On reset=0, SHALL immediately clear all tap, coeff, acc and pop counter registers, force the state to LOAD, and drive dout=0, in_rd_en=0, out_wr_en=0, busy=0, regardless of the current state.
REQ-033 After reset deasserts, SHALL start operating on the first rising edge; reset asserted mid-MAC or mid-WRITE SHALL discard the pending output.

Verification
REQ-034 Impulse test: TAPS=4, DECIM=1, FRAC_BITS=10, coeffs {1024,2048,3072,4096}, input 1,0,0,0 -> outputs 1,2,3,4, each 5 cycles after its triggering pop.
REQ-035 Decimation test: DECIM=4, all coeffs 1024, input 1..8 -> exactly two outputs: 10 (from 1..4) and 26 (from 5..8, with taps holding 8,7,6,5).
REQ-036 Backpressure test: hold out_full=1 for 20 cycles in WRITE -> out_wr_en=0, dout stable and in_rd_en=0 throughout; then exactly one push on release.
REQ-037 Starvation test: in_empty toggling every cycle -> pops occur only on in_empty=0 cycles and the output sequence matches the golden model.
REQ-038 Coeff lock test: write coeff[0]=99 while busy=1 -> coeff[0] is unchanged; the same write at busy=0 takes effect on the next MAC.
REQ-039 Reset test: assert reset during MAC cycle 2 -> out_wr_en is never asserted for that sample, all outputs read 0, and the first post-reset output uses zeroed history.
